// File: rtl/ternary_mac_pkg.sv
// Shared constants and types for the ternary-weight MAC engine.
package ternary_mac_pkg;

  localparam int unsigned N_ELEM = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned W_W    = 2;
  localparam int unsigned ACC_W  = 14;
  localparam int unsigned IDX_W  = $clog2(N_ELEM);

  localparam logic [W_W-1:0] W_ZERO = 2'b00;
  localparam logic [W_W-1:0] W_POS  = 2'b01;
  localparam logic [W_W-1:0] W_NEG  = 2'b11;
  localparam logic [W_W-1:0] W_RSVD = 2'b10;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/ternary_term.sv
// Combinational ternary product: maps an unsigned activation and a 2-bit weight code to a signed term.
module ternary_term
  import ternary_mac_pkg::*;
(
  input  logic        [DATA_W-1:0] data,
  input  logic        [W_W-1:0]    code,
  output logic signed [ACC_W-1:0]  term
);

  logic signed [ACC_W-1:0] ext;

  assign ext = signed'({{(ACC_W-DATA_W){1'b0}}, data});

  always_comb begin
    term = '0;
    unique case (code)
      W_POS:   term = ext;
      W_NEG:   term = -ext;
      W_ZERO:  term = '0;
      W_RSVD:  term = '0;
      default: term = '0;
    endcase
  end

endmodule

// File: rtl/ternary_mac.sv
// Sequential ternary-weight dot product, one element per cycle, with registered activation output.
// Build option: define TERNARY_MAC_RELU_EN for a saturating ReLU on act_out; otherwise act_out is result[7:0].
module ternary_mac
  import ternary_mac_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [N_ELEM*W_W-1:0]     weights,
  input  logic [N_ELEM*DATA_W-1:0]  data,
  output logic                      busy,
  output logic                      done,
  output logic signed [ACC_W-1:0]   result,
  output logic [7:0]                act_out
);

  state_t                             state;
  logic signed [ACC_W-1:0]            acc;
  logic [IDX_W-1:0]                   idx;
  logic [N_ELEM-1:0][W_W-1:0]         w_snap;
  logic [N_ELEM-1:0][DATA_W-1:0]      d_snap;
  logic signed [ACC_W-1:0]            term;
  logic signed [ACC_W-1:0]            sum;
  logic [7:0]                         act_next;

  ternary_term u_term (
    .data (d_snap[idx]),
    .code (w_snap[idx]),
    .term (term)
  );

  assign sum  = acc + term;
  assign busy = (state == S_RUN);

`ifdef TERNARY_MAC_RELU_EN
  // Negative clamps to 0; any bit above the low byte of a positive sum means > 255.
  always_comb begin
    act_next = sum[7:0];
    if (sum[ACC_W-1])
      act_next = '0;
    else if (|sum[ACC_W-2:8])
      act_next = '1;
  end
`else
  always_comb begin
    act_next = sum[7:0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      acc     <= '0;
      idx     <= '0;
      w_snap  <= '0;
      d_snap  <= '0;
      result  <= '0;
      act_out <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            w_snap <= weights;
            d_snap <= data;
            acc    <= '0;
            idx    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (idx == IDX_W'(N_ELEM - 1)) begin
            result  <= sum;
            act_out <= act_next;
            done    <= 1'b1;
            idx     <= '0;
            state   <= S_IDLE;
          end else begin
            acc <= sum;
            idx <= idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
